// File: rtl/pong_renderer.sv
// Two-stage Pong pixel renderer: stage 1 registers object hit flags for the
// current and previous frame snapshots, stage 2 resolves priority, colour and dirtiness.
module pong_renderer #(
  parameter int SCREEN_W     = 800,
  parameter int BALL_SIZE    = 4,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 32,
  parameter int PADDLE_INSET = 16,
  parameter int SEG_LEN      = 32,
  parameter int SEG_THK      = 8,
  parameter int DIRTY_ONLY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        frame_start,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  leftPaddle_y,
  input  logic [9:0]  rightPaddle_y,
  input  logic [3:0]  LS,
  input  logic [3:0]  RS,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [31:0] spriteID,
  output logic        updatePixel,
  output logic [15:0] pong_cRGB,
  output logic        valid_out
);

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] lpy;
    logic [9:0] rpy;
    logic [3:0] ls;
    logic [3:0] rs;
  } snap_t;

  localparam logic [10:0] BALL_LEN = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
  localparam logic [10:0] PAD_H    = 11'(PADDLE_H);
  localparam logic [10:0] LPAD_X   = 11'(PADDLE_INSET);
  localparam logic [10:0] RPAD_X   = 11'(SCREEN_W - PADDLE_INSET - PADDLE_W);
  localparam logic [10:0] LINE_LO  = 11'(SCREEN_W / 2 - 2);
  localparam logic [10:0] LINE_HI  = 11'(SCREEN_W / 2 + 2);
  localparam logic [10:0] SL       = 11'(SEG_LEN);
  localparam logic [10:0] ST       = 11'(SEG_THK);
  localparam logic [10:0] SL_T     = 11'(SEG_LEN - SEG_THK);
  localparam logic [10:0] SL2_T    = 11'(2 * SEG_LEN - SEG_THK);
  localparam logic [10:0] SL2_2T   = 11'(2 * SEG_LEN - 2 * SEG_THK);
  localparam logic [10:0] BOX_Y    = 11'd64;
  localparam logic [10:0] LBOX_X   = 11'(SCREEN_W / 2 - 64);
  localparam logic [10:0] LTENS_X  = 11'(SCREEN_W / 2 - 64 - 3 * SEG_THK);
  localparam logic [10:0] RBOX_X   = 11'(SCREEN_W / 2 + 64 - SEG_LEN);
  localparam logic [10:0] RBOX_SH  = 11'(SCREEN_W / 2 + 64 - SEG_LEN + 2 * SEG_THK);

  // Upper bound kept at 12 bits so an object near 1023 extends without wrapping.
  function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] len);
    logic [11:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (p >= lo) && ({1'b0, p} <= hi);
  endfunction

  function automatic logic in_ho(input logic [10:0] p, input logic [10:0] lo,
                                 input logic [10:0] len);
    return (p >= lo) && ({1'b0, p} < ({1'b0, lo} + {1'b0, len}));
  endfunction

  function automatic logic digit_hit(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] ox, input logic [3:0] score);
    logic [3:0]  glyph;
    logic [6:0]  seg;  // {a,b,c,d,e,f,g}
    logic [10:0] dx;
    logic [10:0] dy;
    glyph = (score >= 4'd10) ? 4'(score - 4'd10) : score;
    case (glyph)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      default: seg = 7'b1111011;
    endcase
    if (px < ox || py < BOX_Y) return 1'b0;
    dx = px - ox;
    dy = py - BOX_Y;
    return (seg[6] && dx < SL && dy < ST)
        || (seg[5] && dx >= SL_T && dx < SL && dy < SL)
        || (seg[4] && dx >= SL_T && dx < SL && dy >= SL_T && dy < SL2_T)
        || (seg[3] && dx < SL && dy >= SL2_2T && dy < SL2_T)
        || (seg[2] && dx < ST && dy >= SL_T && dy < SL2_T)
        || (seg[1] && dx < ST && dy < SL)
        || (seg[0] && dx < SL && dy >= SL_T && dy < SL);
  endfunction

  function automatic logic tens_hit(input logic [10:0] px, input logic [10:0] py,
                                    input logic [10:0] tx);
    return in_ho(px, tx, ST) && in_ho(py, BOX_Y, SL2_T);
  endfunction

  // Hit set bits: [0] ball, [1] left paddle, [2] right paddle, [3] centre line, [4] score.
  function automatic logic [4:0] hit_set(input snap_t s, input logic [10:0] px,
                                         input logic [10:0] py);
    logic [4:0]  h;
    logic [10:0] rx;
    rx   = (s.rs >= 4'd10) ? RBOX_SH : RBOX_X;
    h[0] = in_span(px, {1'b0, s.bx}, BALL_LEN) && in_span(py, {1'b0, s.by}, BALL_LEN);
    h[1] = in_span(px, LPAD_X, PAD_W) && in_span(py, {1'b0, s.lpy}, PAD_H);
    h[2] = in_span(px, RPAD_X, PAD_W) && in_span(py, {1'b0, s.rpy}, PAD_H);
    h[3] = (px >= LINE_LO) && (px <= LINE_HI);
    h[4] = digit_hit(px, py, LBOX_X, s.ls) || (s.ls >= 4'd10 && tens_hit(px, py, LTENS_X))
        || digit_hit(px, py, rx, s.rs)     || (s.rs >= 4'd10 && tens_hit(px, py, RBOX_X));
    return h;
  endfunction

  function automatic logic [2:0] top_sprite(input logic [4:0] h);
    if (h[0]) return 3'd1;
    if (h[1]) return 3'd2;
    if (h[2]) return 3'd3;
    if (h[3]) return 3'd4;
    if (h[4]) return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [1:0] colour_class(input logic [2:0] id);
    case (id)
      3'd1, 3'd2, 3'd3: return 2'd2;
      3'd4, 3'd5:       return 2'd1;
      default:          return 2'd0;
    endcase
  endfunction

  snap_t      live_snap, cur_q, prev_q;
  logic       v1_q;
  logic [4:0] cur_hit_q, prev_hit_q;
  logic       valid_q, valid_d, upd_q, upd_d, cov_q, cov_d;
  logic [7:0] colour_q, colour_d;
  logic [2:0] sprite_q, sprite_d;

  assign live_snap = '{bx: ball_x, by: ball_y, lpy: leftPaddle_y, rpy: rightPaddle_y,
                       ls: LS, rs: RS};

  // NOTE: sequential state uses non-blocking assignment so prev_q takes the
  // pre-edge cur_q and stage 1 sees the pre-edge snapshot in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else if (frame_start) begin
      prev_q <= cur_q;
      cur_q  <= live_snap;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q       <= 1'b0;
      cur_hit_q  <= '0;
      prev_hit_q <= '0;
    end else begin
      v1_q       <= pixel_valid;
      cur_hit_q  <= hit_set(cur_q, x, y);
      prev_hit_q <= hit_set(prev_q, x, y);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    valid_d  = 1'b0;
    sprite_d = 3'd0;
    colour_d = 8'd0;
    cov_d    = 1'b0;
    upd_d    = 1'b0;
    if (v1_q) begin
      valid_d  = 1'b1;
      sprite_d = top_sprite(cur_hit_q);
      case (colour_class(sprite_d))
        2'd2:    colour_d = 8'd255;
        2'd1:    colour_d = 8'd127;
        default: colour_d = 8'd0;
      endcase
      cov_d = |cur_hit_q;
      upd_d = (DIRTY_ONLY == 0) || (cur_hit_q != prev_hit_q)
           || (colour_class(sprite_d) != colour_class(top_sprite(prev_hit_q)));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      sprite_q <= 3'd0;
      colour_q <= 8'd0;
      cov_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sprite_q <= sprite_d;
      colour_q <= colour_d;
      cov_q    <= cov_d;
      upd_q    <= upd_d;
    end
  end

  assign valid_out   = valid_q;
  assign R           = colour_q;
  assign G           = colour_q;
  assign B           = colour_q;
  assign spriteID    = {29'd0, sprite_q};
  assign updatePixel = upd_q;
  assign pong_cRGB   = {cov_q, colour_q[7:3], colour_q[7:3], colour_q[7:3]};

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: default instance plus a DIRTY_ONLY=0
// instance sharing the same stimulus; expectations are hand-computed for SCREEN_W=800.
module tb_pong_renderer;

  logic        clock = 1'b0;
  logic        reset, pixel_valid, frame_start;
  logic [10:0] x, y;
  logic [9:0]  ball_x, ball_y, leftPaddle_y, rightPaddle_y;
  logic [3:0]  LS, RS;

  logic [7:0]  R, G, B, R2, G2, B2;
  logic [31:0] spriteID, spriteID2;
  logic        updatePixel, updatePixel2, valid_out, valid_out2;
  logic [15:0] pong_cRGB, pong_cRGB2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pong_renderer dut (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .ball_x(ball_x), .ball_y(ball_y),
    .leftPaddle_y(leftPaddle_y), .rightPaddle_y(rightPaddle_y), .LS(LS), .RS(RS),
    .R(R), .G(G), .B(B), .spriteID(spriteID), .updatePixel(updatePixel),
    .pong_cRGB(pong_cRGB), .valid_out(valid_out)
  );

  pong_renderer #(.DIRTY_ONLY(0)) dut_all (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .ball_x(ball_x), .ball_y(ball_y),
    .leftPaddle_y(leftPaddle_y), .rightPaddle_y(rightPaddle_y), .LS(LS), .RS(RS),
    .R(R2), .G(G2), .B(B2), .spriteID(spriteID2), .updatePixel(updatePixel2),
    .pong_cRGB(pong_cRGB2), .valid_out(valid_out2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_live(input logic [9:0] bx, input logic [9:0] by, input logic [9:0] lp,
                          input logic [9:0] rp, input logic [3:0] ls, input logic [3:0] rs);
    ball_x = bx; ball_y = by; leftPaddle_y = lp; rightPaddle_y = rp; LS = ls; RS = rs;
  endtask

  task automatic frame();
    @(negedge clock); frame_start = 1'b1;
    @(negedge clock); frame_start = 1'b0;
  endtask

  // Presents one pixel and returns at the negedge after its result is registered.
  task automatic render(input string tag, input logic [10:0] px, input logic [10:0] py);
    @(negedge clock); x = px; y = py; pixel_valid = 1'b1;
    @(negedge clock); pixel_valid = 1'b0;
    check({tag, ".lat1"}, valid_out, 0);
    @(negedge clock);
  endtask

  task automatic expect_px(input string tag, input logic [10:0] px, input logic [10:0] py,
                           input logic [31:0] sid, input logic [7:0] col);
    logic [4:0] c5;
    c5 = col[7:3];
    render(tag, px, py);
    check({tag, ".valid"}, valid_out, 1);
    check({tag, ".sprite"}, spriteID, sid);
    check({tag, ".R"}, R, col);
    check({tag, ".G"}, G, col);
    check({tag, ".B"}, B, col);
    check({tag, ".crgb"}, pong_cRGB, {16'd0, (sid != 0), c5, c5, c5});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0; x = '0; y = '0;
    set_live(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("rst.valid", valid_out, 0);
    check("rst.sprite", spriteID, 0);
    check("rst.R", R, 0);
    check("rst.crgb", pong_cRGB, 0);
    check("rst.upd", updatePixel, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Zero snapshot before any frame_start
    expect_px("zero_ball", 2, 2, 1, 255);
    check("zero_ball.upd", updatePixel, 0);
    expect_px("zero_lpad", 20, 10, 2, 255);
    expect_px("zero_rpad", 780, 10, 3, 255);
    expect_px("zero_score", 340, 66, 5, 127);

    set_live(100, 50, 200, 300, 0, 0);
    frame();
    expect_px("ball", 102, 52, 1, 255);
    check("ball.crgb_ffff", pong_cRGB, 16'hFFFF);
    check("ball.upd", updatePixel, 1);
    expect_px("ball_edge", 104, 54, 1, 255);
    expect_px("ball_out", 105, 52, 0, 0);
    check("ball_out.upd", updatePixel, 0);
    check("ball_out.upd_all", updatePixel2, 1);

    set_live(200, 50, 200, 300, 0, 0);
    expect_px("old_snap", 102, 52, 1, 255);
    frame();
    expect_px("moved", 102, 52, 0, 0);
    check("moved.upd", updatePixel, 1);
    frame();
    expect_px("static_old", 102, 52, 0, 0);
    check("static_old.upd", updatePixel, 0);
    expect_px("static_ball", 202, 52, 1, 255);
    check("static_ball.upd", updatePixel, 0);
    expect_px("static_bg", 600, 500, 0, 0);
    check("static_bg.upd", updatePixel, 0);
    check("static_bg.upd_all", updatePixel2, 1);
    check("static_bg.valid_all", valid_out2, 1);

    expect_px("line_lo", 398, 10, 4, 127);
    expect_px("line_below", 397, 10, 0, 0);
    expect_px("line_hi", 402, 10, 4, 127);
    expect_px("line_above", 403, 10, 0, 0);
    expect_px("lpad_in", 20, 210, 2, 255);
    expect_px("lpad_corner", 24, 232, 2, 255);
    expect_px("lpad_out", 25, 210, 0, 0);
    expect_px("rpad_corner", 784, 332, 3, 255);
    expect_px("rpad_out_x", 785, 332, 0, 0);
    expect_px("rpad_out_y", 780, 333, 0, 0);

    set_live(398, 300, 200, 300, 0, 0);
    frame();
    expect_px("ball_on_line", 399, 301, 1, 255);

    set_live(200, 50, 200, 300, 12, 0);
    frame();
    expect_px("tens_left", 312, 70, 5, 127);
    check("tens_left.crgb_bdef", pong_cRGB, 16'hBDEF);
    expect_px("digit2_a", 340, 66, 5, 127);
    expect_px("digit2_c_off", 364, 104, 0, 0);
    set_live(200, 50, 200, 300, 2, 0);
    frame();
    expect_px("tens_gone", 312, 70, 0, 0);
    check("tens_gone.upd", updatePixel, 1);
    set_live(200, 50, 200, 300, 9, 0);
    frame();
    expect_px("digit9_d", 340, 115, 5, 127);
    set_live(200, 50, 200, 300, 6, 0);
    frame();
    expect_px("digit6_a", 350, 66, 5, 127);
    set_live(200, 50, 200, 300, 6, 10);
    frame();
    expect_px("tens_right", 436, 90, 5, 127);
    expect_px("rdigit_shift_a", 476, 66, 5, 127);
    expect_px("rdigit0_centre", 464, 90, 0, 0);

    set_live(1020, 50, 200, 300, 0, 0);
    frame();
    expect_px("clip_1024", 1024, 52, 1, 255);
    expect_px("clip_1025", 1025, 52, 0, 0);
    expect_px("no_wrap", 2, 52, 0, 0);

    // Pixel coincident with frame_start renders from the old snapshot
    set_live(500, 500, 200, 300, 0, 0);
    @(negedge clock); frame_start = 1'b1; pixel_valid = 1'b1; x = 502; y = 502;
    @(negedge clock); frame_start = 1'b0; pixel_valid = 1'b0;
    @(negedge clock);
    check("fs_same.valid", valid_out, 1);
    check("fs_same.sprite", spriteID, 0);
    expect_px("fs_after", 502, 502, 1, 255);

    // Reset in the middle of back-to-back pixels
    @(negedge clock); x = 2; y = 2; pixel_valid = 1'b1;
    @(negedge clock); reset = 1'b1;
    #1;
    check("rst_mid.valid", valid_out, 0);
    @(negedge clock);
    check("rst_held.valid", valid_out, 0);
    check("rst_held.valid_all", valid_out2, 0);
    reset = 1'b0; pixel_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_after.valid", valid_out, 0);
    end
    expect_px("rst_new", 2, 2, 1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
